// File: rtl/keypad_entry.sv
// Keypad entry buffer: collects digit pulses into a packed BCD entry with backspace, abort and submit.
// Optional inactivity timeout is compiled in when KEYPAD_TIMEOUT_EN is defined.
module keypad_entry #(
   parameter int unsigned MAX_DIGITS     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic                               CLK,
   input  logic                               RST,
   input  logic [9:0]                         I_BUTTON,
   input  logic                               I_STAR,
   input  logic                               I_HASH,
   output logic [4*MAX_DIGITS-1:0]            O_DIGITS,
   output logic [$clog2(MAX_DIGITS+1)-1:0]    O_COUNT,
   output logic [4*MAX_DIGITS-1:0]            O_CODE,
   output logic [$clog2(MAX_DIGITS+1)-1:0]    O_LEN,
   output logic                               O_VALID,
   output logic                               O_ERROR,
   output logic                               O_TIMEOUT
);

   localparam int unsigned DW = 4 * MAX_DIGITS;
   localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

   typedef enum logic {
      IDLE,
      ENTRY
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] digits_d, code_d;
   logic [CW-1:0] count_d, len_d;
   logic          valid_d, error_d;

   logic          btn_any, btn_multi;
   logic [3:0]    dig;
   logic          ev_illegal, ev_abort, ev_bksp, ev_submit, ev_digit;
   logic          ev_expire;

   always_comb begin : classify
      dig = '0;
      for (int unsigned i = 0; i < 10; i++) begin
         if (I_BUTTON[i]) dig = 4'(i);
      end
      btn_any    = |I_BUTTON;
      btn_multi  = (I_BUTTON & (I_BUTTON - 10'd1)) != '0;
      ev_illegal = btn_any && (btn_multi || I_STAR || I_HASH);
      ev_abort   = !btn_any && I_STAR && I_HASH;
      ev_bksp    = !btn_any && I_STAR && !I_HASH;
      ev_submit  = !btn_any && !I_STAR && I_HASH;
      ev_digit   = btn_any && !btn_multi && !I_STAR && !I_HASH;
   end

`ifdef KEYPAD_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] timer_q, timer_d;
   logic          ev_any;

   always_comb begin : timer_next
      ev_any    = btn_any || I_STAR || I_HASH;
      ev_expire = !ev_any && (state_q == ENTRY) && (timer_q == TLAST);
      timer_d   = '0;
      // Any event, including rejected ones, restarts the idle count
      if (!ev_any && (state_q == ENTRY) && (timer_q != TLAST))
         timer_d = timer_q + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         timer_q   <= '0;
         O_TIMEOUT <= 1'b0;
      end else begin
         timer_q   <= timer_d;
         O_TIMEOUT <= ev_expire;
      end
   end
`else
   assign ev_expire = 1'b0;
   assign O_TIMEOUT = 1'b0;
`endif

   always_comb begin : next_state
      state_d  = state_q;
      digits_d = O_DIGITS;
      count_d  = O_COUNT;
      code_d   = O_CODE;
      len_d    = O_LEN;
      valid_d  = 1'b0;
      error_d  = 1'b0;

      if (ev_illegal) begin
         error_d = 1'b1;
      end else if (ev_abort) begin
         digits_d = '0;
         count_d  = '0;
         state_d  = IDLE;
      end else if (ev_bksp) begin
         if (O_COUNT != '0) begin
            digits_d = O_DIGITS >> 4;
            count_d  = O_COUNT - 1'b1;
            if (O_COUNT == CW'(1)) state_d = IDLE;
         end
      end else if (ev_submit) begin
         if (O_COUNT != '0) begin
            code_d   = O_DIGITS;
            len_d    = O_COUNT;
            valid_d  = 1'b1;
            digits_d = '0;
            count_d  = '0;
            state_d  = IDLE;
         end else begin
            error_d = 1'b1;
         end
      end else if (ev_digit) begin
         if (O_COUNT == CW'(MAX_DIGITS)) begin
            error_d = 1'b1;
         end else begin
            digits_d = (O_DIGITS << 4) | DW'(dig);
            count_d  = O_COUNT + 1'b1;
            state_d  = ENTRY;
         end
      end else if (ev_expire) begin
         digits_d = '0;
         count_d  = '0;
         state_d  = IDLE;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         O_DIGITS <= '0;
         O_COUNT  <= '0;
         O_CODE   <= '0;
         O_LEN    <= '0;
         O_VALID  <= 1'b0;
         O_ERROR  <= 1'b0;
      end else begin
         state_q  <= state_d;
         O_DIGITS <= digits_d;
         O_COUNT  <= count_d;
         O_CODE   <= code_d;
         O_LEN    <= len_d;
         O_VALID  <= valid_d;
         O_ERROR  <= error_d;
      end
   end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Consumer end of the keypad pulse interface. Takes the one-cycle rising-edge pulses from the button edge-detect stage: 10 digit lines, STAR and HASH.
- Builds a multi-digit BCD entry. STAR is backspace, STAR+HASH together aborts, HASH submits.
- A submitted code is latched and flagged for the downstream lock/compare logic.
- Sits between the button conditioning stage and the application FSM.

Parameters:
- MAX_DIGITS, 4, maximum digits held in the entry buffer (>=1).
- TIMEOUT_CYCLES, 1000, idle cycles with a non-empty buffer before the entry is discarded (>=2).

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RST  input  1  synchronous, active-high reset.
- I_BUTTON  input  10  digit pulses; bit k = digit k; each pulse lasts 1 cycle.
- I_STAR  input  1  STAR pulse.
- I_HASH  input  1  HASH pulse.
- O_DIGITS  output  4*MAX_DIGITS  live entry buffer, packed BCD; newest digit in [3:0].
- O_COUNT  output  $clog2(MAX_DIGITS+1)  digits currently held.
- O_CODE  output  4*MAX_DIGITS  last submitted code, packed like O_DIGITS, zero-extended.
- O_LEN  output  $clog2(MAX_DIGITS+1)  length of the last submitted code.
- O_VALID  output  1  one-cycle pulse; O_CODE/O_LEN updated.
- O_ERROR  output  1  one-cycle pulse; event rejected.
- O_TIMEOUT  output  1  one-cycle pulse; entry discarded by inactivity.

Behaviour:
- All outputs registered. Every response appears the cycle after the input pulse (latency 1).
- Reset: all outputs 0, timer 0, state IDLE. RST dominates any same-cycle input; reset mid-entry discards the buffer with no pulses.
- Event classification (per cycle):
  - Digit: exactly one I_BUTTON bit set, STAR=HASH=0.
  - Illegal: more than one I_BUTTON bit set, or any I_BUTTON bit together with STAR or HASH. Response: O_ERROR=1, buffer unchanged.
  - Abort: STAR=HASH=1, I_BUTTON=0. Buffer cleared, count 0, no error even if already empty.
  - Backspace: STAR only. If count>0, buffer shifts right 4 (top nibble 0) and count decrements. If count==0, no-op, no error.
  - Submit: HASH only. If count>0, then O_CODE<=O_DIGITS, O_LEN<=O_COUNT, O_VALID=1, and the buffer clears. If count==0, O_ERROR=1 and O_CODE/O_LEN are held.
  - Digit when count<MAX_DIGITS: buffer shifts left 4, new BCD in [3:0], count increments.
  - Digit when count==MAX_DIGITS (full): O_ERROR=1, buffer unchanged, no overwrite.
- State machine:
  - IDLE (count==0) to ENTRY on an accepted digit.
  - ENTRY to IDLE on submit, abort, backspace reaching 0, or timeout.
  - ENTRY stays in ENTRY on any other event.
- Timer:
  - Counts only in ENTRY.
  - Cleared to 0 by any input event, including illegal and rejected events.
  - When the timer reaches TIMEOUT_CYCLES-1 with no event that cycle: buffer cleared, O_TIMEOUT=1 next cycle, return to IDLE.
  - An event on the expiry cycle wins and the timeout is cancelled.
- O_VALID, O_ERROR and O_TIMEOUT are mutually exclusive and never asserted for 2 consecutive cycles from a single event.
- O_CODE/O_LEN change only on a valid submit. Otherwise they hold, including through abort and timeout.

Optional Feature:
- Macro KEYPAD_TIMEOUT_EN.
- Defined: timer and timeout behaviour as above.
- Undefined: no timer logic, O_TIMEOUT tied to 0, entry persists indefinitely. All other behaviour is identical.

Test Plan:
- Digits 1,2,3 then HASH, MAX_DIGITS=4 -> after HASH: O_VALID=1 for 1 cycle, O_CODE=0x0123, O_LEN=3, O_COUNT=0, O_DIGITS=0.
- Digits 9,8,7,6,5 -> the 5th press gives O_ERROR=1; O_DIGITS=0x9876, O_COUNT=4.
- Digits 4,5 then STAR, STAR, STAR -> O_DIGITS 0x0045, then 0x0004, then 0x0000; the 3rd STAR has no error; O_COUNT=0.
- I_BUTTON=10'b0000000110 -> O_ERROR=1, buffer unchanged. Digit 2 with HASH in the same cycle -> O_ERROR=1, no submit.
- Digit 7, idle TIMEOUT_CYCLES cycles, TIMEOUT_CYCLES=16 -> O_TIMEOUT=1 once, O_COUNT=0, O_CODE unchanged. Repeat with digit 3 pressed on the expiry cycle -> no timeout, O_DIGITS=0x0073.
- Digits 1,2, then RST on the same cycle as HASH -> all outputs 0, no O_VALID. STAR+HASH with 2 digits -> buffer 0, no pulse.
